sockit_cdc_arb: RTL and testbench

- Round-robin arbiter that shares one CDC FIFO input port among N requesters in the ffi_clk domain.
- Each requester presents a req/grt/bus stream. The arbiter locks one owner for a burst of up to BL transfers.
- Output goes through a single registered stage that drives the FIFO input (ffi_req/ffi_bus/ffi_grt).
- Transfer rule on every port: a word moves in the cycle where req & grt are both high.

---
 rtl/sockit_cdc_arb.sv | 145 ++++++++++++++
 tb/tb_sockit_cdc_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sockit_cdc_arb.sv
// Round-robin arbiter sharing one CDC FIFO input port among N requesters.
// One owner is locked per burst of up to BL transfers; output is a single registered stage.
module sockit_cdc_arb #(
    parameter int N  = 4,
    parameter int AW = 2,
    parameter int DW = 8,
    parameter int BL = 4
) (
    input  logic            ffi_clk,
    input  logic            ffi_rst,
    input  logic [N*DW-1:0] bsi_bus,
    input  logic [N-1:0]    bsi_req,
    output logic [N-1:0]    bsi_grt,
    output logic [DW-1:0]   ffi_bus,
    output logic            ffi_req,
    input  logic            ffi_grt,
    output logic            sts_act,
    output logic [AW-1:0]   sts_own
);

    localparam int CW = (BL > 1) ? $clog2(BL) + 1 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((BL == 0) ? 0 : BL - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [AW-1:0] OWN_RST  = AW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   own_q, own_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d;
    logic [DW-1:0]   bus_q, bus_d;

    logic            busy;
    logic            ld;
    logic            own_req;
    logic            xfer;
    logic            any_req;
    logic            rel;
    logic [N-1:0]    grt;
    logic [AW-1:0]   nxt;
    logic [DW-1:0]   sel_word;

    // Next owner: scan own+1 .. own cyclically, so the current owner is checked last.
    always_comb begin
        logic [AW:0] cand;
        logic        found;
        nxt   = own_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, own_q} + (AW+1)'(k);
            if (cand >= (AW+1)'(N)) begin
                cand = cand - (AW+1)'(N);
            end
            if (!found && bsi_req[cand[AW-1:0]]) begin
                found = 1'b1;
                nxt   = cand[AW-1:0];
            end
        end
    end

    always_comb begin
        busy     = (state_q == BUSY);
        ld       = ~req_q | ffi_grt;
        own_req  = bsi_req[own_q];
        xfer     = busy & ld & own_req;
        any_req  = |bsi_req;
        sel_word = bsi_bus[int'(own_q)*DW +: DW];
        grt      = '0;
        if (busy && ld) begin
            grt[own_q] = 1'b1;
        end
        // Release on a completed burst or when the owner withdraws its request.
        rel = (xfer && (BL != 0) && (cnt_q == CNT_LAST)) || !own_req;
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    own_d   = nxt;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (rel) begin
                    cnt_d = '0;
                    if (any_req) begin
                        own_d = nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: loads on a requester transfer, empties when the FIFO takes the word.
    always_comb begin
        req_d = req_q;
        bus_d = bus_q;
        if (xfer) begin
            req_d = 1'b1;
            bus_d = sel_word;
        end else if (ffi_grt) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge ffi_clk or posedge ffi_rst) begin
        if (ffi_rst) begin
            state_q <= IDLE;
            own_q   <= OWN_RST;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            bus_q   <= bus_d;
        end
    end

    assign bsi_grt = grt;
    assign ffi_bus = bus_q;
    assign ffi_req = req_q;
    assign sts_act = (state_q == BUSY);
    assign sts_own = own_q;

endmodule

// File: tb/tb_sockit_cdc_arb.sv
// Bench for sockit_cdc_arb: queue-driven requesters, stream scoreboard and fixed round-robin patterns.
// Two instances share stimulus: BL=4 (sel=0) and BL=0 (sel=1).
module tb_sockit_cdc_arb;

    logic        ffi_clk = 1'b0;
    logic        ffi_rst;
    logic [31:0] bsi_bus;
    logic [3:0]  bsi_req;
    logic        ffi_grt;
    logic        sel;

    logic [3:0] a_req, b_req, a_grt, b_grt, o_grt;
    logic [7:0] a_bus, b_bus, o_bus;
    logic       a_freq, b_freq, o_req, a_act, b_act, o_act;
    logic [1:0] a_own, b_own, o_own;

    always #5 ffi_clk = ~ffi_clk;

    assign a_req = sel ? 4'b0 : bsi_req;
    assign b_req = sel ? bsi_req : 4'b0;
    assign o_grt = sel ? b_grt : a_grt;
    assign o_bus = sel ? b_bus : a_bus;
    assign o_req = sel ? b_freq : a_freq;
    assign o_act = sel ? b_act : a_act;
    assign o_own = sel ? b_own : a_own;

    sockit_cdc_arb #(.N(4), .AW(2), .DW(8), .BL(4)) dut (
        .ffi_clk(ffi_clk), .ffi_rst(ffi_rst), .bsi_bus(bsi_bus), .bsi_req(a_req),
        .bsi_grt(a_grt), .ffi_bus(a_bus), .ffi_req(a_freq), .ffi_grt(ffi_grt),
        .sts_act(a_act), .sts_own(a_own)
    );

    sockit_cdc_arb #(.N(4), .AW(2), .DW(8), .BL(0)) dut_u (
        .ffi_clk(ffi_clk), .ffi_rst(ffi_rst), .bsi_bus(bsi_bus), .bsi_req(b_req),
        .bsi_grt(b_grt), .ffi_bus(b_bus), .ffi_req(b_freq), .ffi_grt(ffi_grt),
        .sts_act(b_act), .sts_own(b_own)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] src_q [4][$];
    logic [7:0] out_log[$];
    logic [7:0] exp_log[$];
    int         iseq[4];
    int         nseq[4];
    int         n_in[4];
    bit         en[4];
    bit         fg, rnd_grt, rnd_en;
    bit         pv_in, pv_req, pv_grt;
    logic [7:0] pv_word, pv_bus;
    logic [3:0] xv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mk(input int s, input int q);
        logic [1:0] ss;
        logic [5:0] qq;
        ss = 2'(s);
        qq = 6'(q);
        return {ss, qq};
    endfunction

    task automatic fill(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[s].push_back(mk(s, iseq[s]));
            iseq[s]++;
        end
    endtask

    task automatic clear();
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            iseq[i] = 0;
            nseq[i] = 0;
            n_in[i] = 0;
            en[i]   = 1'b1;
        end
        out_log.delete();
        exp_log.delete();
        pv_in  = 1'b0;
        pv_req = 1'b0;
        pv_grt = 1'b0;
        xv     = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (rnd_en) en[i] = ($urandom_range(0, 3) != 0);
            bsi_req[i] = en[i] && (src_q[i].size() > 0);
            bsi_bus[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
        ffi_grt = rnd_grt ? ($urandom_range(0, 2) != 0) : fg;
    endtask

    // Stream-level invariants that hold in every cycle of every phase.
    task automatic observe();
        int s;
        chk("grt_onehot0", 32'($onehot0(o_grt)), 1);
        if (o_req && !ffi_grt) chk("grt_when_full", o_grt, 0);
        if (pv_in) begin
            chk("lat_req", o_req, 1);
            chk("lat_bus", o_bus, pv_word);
        end else if (pv_req && !pv_grt) begin
            chk("stall_req", o_req, 1);
            chk("stall_bus", o_bus, pv_bus);
        end
        if (o_req && ffi_grt) begin
            s = int'(o_bus[7:6]);
            chk("src_order", o_bus[5:0], 32'(nseq[s] % 64));
            nseq[s]++;
            out_log.push_back(o_bus);
        end
        xv    = bsi_req & o_grt;
        pv_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (xv[i]) begin
                pv_in   = 1'b1;
                pv_word = src_q[i][0];
            end
        end
        pv_req = o_req;
        pv_grt = ffi_grt;
        pv_bus = o_bus;
    endtask

    task automatic settle();
        drive();
        #1;
        observe();
    endtask

    task automatic advance();
        @(posedge ffi_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (xv[i]) begin
                void'(src_q[i].pop_front());
                n_in[i]++;
            end
        end
        xv = '0;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic do_reset(input int n);
        ffi_rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            settle();
            chk("rst_ffi_req", o_req, 0);
            chk("rst_grt", o_grt, 0);
            chk("rst_act", o_act, 0);
            chk("rst_own", o_own, 3);
            chk("rst_bus", o_bus, 0);
            advance();
        end
        clear();
        ffi_rst = 1'b0;
    endtask

    task automatic run_until(input int total, input int budget);
        for (int k = 0; k < budget && out_log.size() < total; k++) cyc();
        chk("drain_count", out_log.size(), total);
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_len"}, out_log.size(), exp_log.size());
        for (int k = 0; k < out_log.size() && k < exp_log.size(); k++)
            chk(tag, out_log[k], exp_log[k]);
    endtask

    task automatic exp_rr(input int words);
        exp_log.delete();
        for (int k = 0; k < words; k++)
            exp_log.push_back(mk((k / 4) % 4, (k / 16) * 4 + k % 4));
    endtask

    initial begin
        int own0, total;
        int len[4];
        ffi_rst = 1'b1;
        sel     = 1'b0;
        fg      = 1'b1;
        rnd_grt = 1'b0;
        rnd_en  = 1'b0;
        bsi_req = '0;
        bsi_bus = '0;
        ffi_grt = 1'b1;
        clear();
        @(posedge ffi_clk);
        #1;

        // Reset held with every requester asking
        for (int i = 0; i < 4; i++) fill(i, 4);
        do_reset(4);

        // Single requester, continuous: back-to-back bursts with no gap
        fill(0, 16);
        settle();
        chk("single_c0_grt", o_grt, 0);
        chk("single_c0_act", o_act, 0);
        chk("single_c0_req", o_req, 0);
        advance();
        for (int c = 1; c <= 16; c++) begin
            settle();
            chk("single_grt0", o_grt, 4'b0001);
            chk("single_act", o_act, 1);
            advance();
        end
        run_until(16, 10);
        exp_log.delete();
        for (int k = 0; k < 16; k++) exp_log.push_back(8'(k));
        cmp_log("single_data");

        // Fairness: four continuous requesters, 4-word bursts in rotation
        do_reset(2);
        for (int i = 0; i < 4; i++) fill(i, 32);
        run_until(128, 400);
        exp_rr(128);
        cmp_log("fair");

        // Fairness under random FIFO backpressure
        do_reset(2);
        for (int i = 0; i < 4; i++) fill(i, 16);
        rnd_grt = 1'b1;
        run_until(64, 600);
        rnd_grt = 1'b0;
        exp_rr(64);
        cmp_log("fair_bp");

        // Directed backpressure mid-burst: burst resumes with its remaining count
        do_reset(2);
        fill(0, 8);
        fill(1, 4);
        for (int k = 0; k < 10 && n_in[0] < 2; k++) cyc();
        chk("bp_pre_in", n_in[0], 2);
        own0 = int'(o_own);
        fg = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("bp_req", o_req, 1);
            chk("bp_grt", o_grt, 0);
            chk("bp_own", o_own, 32'(own0));
            advance();
        end
        fg = 1'b1;
        run_until(12, 60);
        exp_log.delete();
        for (int k = 0; k < 4; k++) exp_log.push_back(mk(0, k));
        for (int k = 0; k < 4; k++) exp_log.push_back(mk(1, k));
        for (int k = 4; k < 8; k++) exp_log.push_back(mk(0, k));
        cmp_log("bp_seq");

        // Early release: owner 1 drops after 2 words while 2 waits
        do_reset(2);
        fill(1, 6);
        fill(2, 4);
        for (int k = 0; k < 10 && n_in[1] < 2; k++) cyc();
        chk("er_pre_in", n_in[1], 2);
        en[1] = 1'b0;
        settle();
        chk("er_own_still1", o_own, 1);
        advance();
        en[1] = 1'b1;
        settle();
        chk("er_own2", o_own, 2);
        chk("er_grt2", o_grt, 4'b0100);
        advance();
        run_until(10, 60);
        exp_log.delete();
        for (int k = 0; k < 2; k++) exp_log.push_back(mk(1, k));
        for (int k = 0; k < 4; k++) exp_log.push_back(mk(2, k));
        for (int k = 2; k < 6; k++) exp_log.push_back(mk(1, k));
        cmp_log("er_seq");

        // Random request dropouts and backpressure: nothing lost or duplicated
        do_reset(2);
        total = 0;
        for (int i = 0; i < 4; i++) begin
            len[i] = int'($urandom_range(5, 20));
            fill(i, len[i]);
            total += len[i];
        end
        rnd_en  = 1'b1;
        rnd_grt = 1'b1;
        run_until(total, 1500);
        rnd_en  = 1'b0;
        rnd_grt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b1;
            chk("rnd_per_src", nseq[i], len[i]);
        end

        // Reset pulse mid-burst: immediate return to reset values
        do_reset(1);
        for (int i = 0; i < 4; i++) fill(i, 8);
        for (int k = 0; k < 6; k++) cyc();
        chk("mid_pre_req", o_req, 1);
        ffi_rst = 1'b1;
        #1;
        chk("mid_rst_req", o_req, 0);
        chk("mid_rst_grt", o_grt, 0);
        chk("mid_rst_act", o_act, 0);
        chk("mid_rst_own", o_own, 3);
        chk("mid_rst_bus", o_bus, 0);
        clear();
        do_reset(1);
        settle();
        chk("mid_post_req", o_req, 0);
        advance();

        // Unlimited bursts (BL=0 instance)
        sel = 1'b1;
        do_reset(2);
        fill(1, 50);
        fill(0, 5);
        en[0] = 1'b0;
        cyc();
        cyc();
        en[0] = 1'b1;
        for (int k = 0; k < 80 && src_q[1].size() > 0; k++) begin
            settle();
            chk("bl0_no_grt0", o_grt[0], 0);
            chk("bl0_own1", o_own, 1);
            advance();
        end
        settle();
        chk("bl0_rel_own", o_own, 1);
        advance();
        settle();
        chk("bl0_sw_own", o_own, 0);
        chk("bl0_sw_grt", o_grt, 4'b0001);
        advance();
        run_until(55, 40);
        exp_log.delete();
        for (int k = 0; k < 50; k++) exp_log.push_back(mk(1, k));
        for (int k = 0; k < 5; k++) exp_log.push_back(mk(0, k));
        cmp_log("bl0_seq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
